multdiv_unit: RTL
=================

// Module: multdiv_unit
// PURPOSE
//  Iterative signed 32-bit multiply/divide unit in the execute stage, issued on the
//  same cycle as the ALU op. Result is carried to writeback and written into the
//  register file; data_exception drives the rstatus (r30) write on overflow/div-by-0.
//  Uniform fixed latency, one operation in flight, stall-driven by data_busy.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clock            in   1      rising-edge clock
//  ctrl_reset       in   1      asynchronous, active-high reset
//  ctrl_MULT        in   1      one-cycle start pulse: multiply
//  ctrl_DIV         in   1      one-cycle start pulse: divide
//  data_operandA    in   WIDTH  multiplicand / dividend (two's complement)
//  data_operandB    in   WIDTH  multiplier / divisor (two's complement)
//  data_result      out  WIDTH  low WIDTH bits of product, or quotient
//  data_exception   out  1      overflow (mult) or div-by-zero/overflow (div)
//  data_resultRDY   out  1      result valid; high exactly one cycle
//  data_busy        out  1      operation in progress (pipeline stall request)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): state IDLE, counter 0, all outputs 0.
//  - Operands sampled only on the rising edge where ctrl_MULT|ctrl_DIV is high
//    (edge E0). Inputs may change freely afterwards.
//  - FSM: IDLE -> MUL|DIV on start; MUL/DIV run WIDTH iteration edges (E1..E_WIDTH);
//    -> DONE at E_WIDTH+1: data_result/data_exception/data_resultRDY registered;
//    DONE -> IDLE next edge (or straight to MUL/DIV if a start pulse is present).
//  - Latency: data_resultRDY high during the cycle after E_(WIDTH+1) = 33 edges.
//  - data_busy high from the cycle after E0 until the cycle data_resultRDY rises.
//  - data_result/data_exception hold their value after RDY drops until next DONE.
//  - Both ctrl_MULT and ctrl_DIV high: treated as MULT.
//  - Start pulse while busy: current op aborted, no RDY for it, new op restarts at E0.
//  - Multiply: radix-2 Booth, 2*WIDTH+1-bit product register, one step per edge.
//    Result = product[WIDTH-1:0]. Exception = 1 iff product[2*WIDTH-1:WIDTH-1] is not
//    all-0 or all-1 (product does not fit signed WIDTH).
//  - Divide: operands converted to magnitude, non-restoring (or restoring) shift-subtract
//    one quotient bit per edge, quotient negated iff signs differ; truncate toward 0;
//    remainder discarded.
//  - Divisor 0: full latency still taken; result 0, exception 1.
//  - Dividend 0x80000000 / -1: result 0x80000000, exception 1.
//  - Dividend 0 / nonzero: result 0, exception 0.
// STRUCTURE
//  - Package multdiv_pkg: WIDTH default, FSM state encoding (IDLE, MUL, DIV, DONE),
//    counter width localparam ($clog2(WIDTH)+1).
//  - Sub-module signed_divider_core: magnitude conversion + shift-subtract datapath,
//    step enable and final sign fix; top level holds FSM, counter, Booth datapath,
//    output registers.
//  - Single clock domain; no negedge logic (regfile write on negedge is downstream).
// TESTING
//  - MULT 6 x 4 at E0 -> RDY one cycle after E33, result 24, exception 0, busy 32 cycles.
//  - MULT 0x40000000 x 4 -> result 0x00000000, exception 1; -3 x 5 -> 0xFFFFFFF1, exc 0.
//  - DIV -7 / 2 -> 0xFFFFFFFD (-3), exc 0; DIV 100 / -10 -> 0xFFFFFFF6, exc 0.
//  - DIV 5 / 0 -> result 0, exception 1 at same 33-edge latency;
//    DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
//  - MULT 3x3, then DIV 9/3 pulsed at E10 -> exactly one RDY, at E10+33, result 3.
//  - ctrl_reset asserted mid-MULT (between clocks) -> outputs 0 immediately, no RDY
//    afterwards; next MULT 2x2 -> 4 after full latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
// Holds the default operand width, the FSM encoding and the counter sizing helper.
package multdiv_pkg;

  localparam int DEF_WIDTH = 32;

  // Counter must be able to hold the value WIDTH itself (the "finished" count).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/signed_divider_core.sv
// Signed divider datapath: magnitude conversion at load, one restoring
// shift-subtract quotient bit per step, sign fix on the quotient output.
// Also flags divide-by-zero and MIN/-1 overflow, captured at load.
module signed_divider_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero,
  output logic             div_ovf
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's complement magnitude; MIN maps to 2^(WIDTH-1), which fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   shifted;

  // Load magnitudes on start; each step shifts the next dividend bit into the
  // partial remainder and subtracts the divisor when it fits.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    if (load) begin
      rem_d  = '0;
      quo_d  = mag(dividend);
      dvs_d  = mag(divisor);
      neg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      zero_d = (divisor == '0);
      ovf_d  = (dividend == MIN_VAL) && (&divisor);
    end else if (step) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign quotient = neg_q ? (~quo_q + 1'b1) : quo_q;
  assign div_zero = zero_q;
  assign div_ovf  = ovf_q;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide unit with fixed latency:
// start sampled at E0, WIDTH iteration edges, result registered one edge later.
// One op in flight; a new start pulse aborts the current op; data_busy stalls the pipe.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic               start;
  logic               div_step;
  logic [WIDTH-1:0]   div_quot;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH:0]     acc, mext, sum;
  logic               mult_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  // One Booth step: add/subtract multiplicand into the upper half (one guard
  // bit so MIN multiplicand cannot overflow), then arithmetic shift right.
  always_comb begin
    acc  = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    mext = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   sum = acc + mext;
      2'b10:   sum = acc - mext;
      default: sum = acc;
    endcase
    prod_step = {sum, prod_q[WIDTH:1]};
  end

  // Product bits [2W-1:W-1] live at register bits [2W:W]; must be pure sign.
  assign mult_exc = !((&prod_q[2*WIDTH:WIDTH]) || (~|prod_q[2*WIDTH:WIDTH]));

  // FSM next state, iteration counter, Booth register and output capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    res_d    = res_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    div_step = 1'b0;
    if (start) begin
      state_d = ctrl_MULT ? ST_MUL : ST_DIV;
      cnt_d   = '0;
      prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      mcand_d = data_operandA;
    end else begin
      case (state_q)
        ST_MUL, ST_DIV: begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
            if (state_q == ST_MUL) begin
              res_d = prod_q[WIDTH:1];
              exc_d = mult_exc;
            end else if (div_zero) begin
              res_d = '0;
              exc_d = 1'b1;
            end else begin
              res_d = div_quot;
              exc_d = div_ovf;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == ST_MUL) prod_d = prod_step;
            else                   div_step = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = ((state_d == ST_MUL) || (state_d == ST_DIV)) && (cnt_d != LAST);
  end

  // All control and output state, cleared asynchronously.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  signed_divider_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clock),
    .rst      (ctrl_reset),
    .load     (start),
    .step     (div_step),
    .dividend (data_operandA),
    .divisor  (data_operandB),
    .quotient (div_quot),
    .div_zero (div_zero),
    .div_ovf  (div_ovf)
  );

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign data_busy      = busy_q;

endmodule
